// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS main control FSM.
// Sequences fetch, decode, execute, memory and writeback for one instruction
// at a time. The state register and the retired-instruction counter are the
// only storage. All strobes and mux selects are decoded from the current
// state and the IR fields, so a ready handshake is acted on in the same cycle
// it arrives.
//
// state | meaning
// IF    | request instruction, load IR and PC+4 on inst_ready
// ID    | IR fields settle, register file read
// EX    | ALU operation, branch/jump PC update
// LD    | data read request held until data_ready
// ST    | data write request held until data_ready
// WB    | register file write
module mips_multicycle_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  input  logic        alu_zero,
  input  logic        inst_ready,
  input  logic        data_ready,
  output logic        inst_req,
  output logic        data_req,
  output logic        mem_write,
  output logic        ir_write,
  output logic        pc_write,
  output logic [1:0]  pc_src,
  output logic        reg_write,
  output logic [1:0]  wb_src,
  output logic [1:0]  reg_dst,
  output logic [1:0]  alu_code,
  output logic [2:0]  additional_control,
  output logic [2:0]  state,
  output logic [31:0] retire_cnt
);

  typedef enum logic [2:0] {
    S_IF = 3'd0,
    S_ID = 3'd1,
    S_EX = 3'd2,
    S_LD = 3'd3,
    S_ST = 3'd4,
    S_WB = 3'd5
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] FN_JR    = 6'b001000;
  localparam logic [5:0] FN_JALR  = 6'b001001;

  state_t      state_q, state_d;
  logic [31:0] retire_q, retire_d;

  logic       is_rtype, is_jr, is_jalr, is_jal;
  logic [1:0] dec_alu_code;
  logic [2:0] dec_addl;

  // Instruction class and ALU-control decode from the IR fields.
  always_comb begin
    is_rtype     = (opcode == OP_RTYPE);
    is_jr        = is_rtype && (funct == FN_JR);
    is_jalr      = is_rtype && (funct == FN_JALR);
    is_jal       = (opcode == OP_JAL);
    dec_alu_code = 2'b00;
    dec_addl     = 3'b000;
    case (opcode)
      OP_RTYPE:       dec_alu_code = 2'b10;
      OP_BEQ, OP_BNE: dec_alu_code = 2'b01;
      OP_SLTI:        dec_addl     = 3'b001;
      OP_ANDI:        dec_addl     = 3'b010;
      OP_ORI:         dec_addl     = 3'b011;
      OP_XORI:        dec_addl     = 3'b100;
      default:        ;
    endcase
  end

  // Next-state and decoded outputs; reset overrides every strobe and select.
  always_comb begin
    state_d            = state_q;
    inst_req           = 1'b0;
    data_req           = 1'b0;
    mem_write          = 1'b0;
    ir_write           = 1'b0;
    pc_write           = 1'b0;
    pc_src             = 2'b00;
    reg_write          = 1'b0;
    wb_src             = 2'b00;
    reg_dst            = 2'b00;
    alu_code           = 2'b00;
    additional_control = 3'b000;

    case (state_q)
      S_IF: begin
        inst_req = 1'b1;
        if (inst_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = S_ID;
        end
      end
      S_ID: state_d = S_EX;
      S_EX: begin
        alu_code           = dec_alu_code;
        additional_control = dec_addl;
        case (opcode)
          OP_RTYPE: begin
            if (is_jr || is_jalr) begin
              pc_write = 1'b1;
              pc_src   = 2'b11;
            end
            state_d = is_jr ? S_IF : S_WB;
          end
          OP_BEQ, OP_BNE: begin
            // beq takes the branch on zero, bne on non-zero
            if (alu_zero == (opcode == OP_BEQ)) begin
              pc_write = 1'b1;
              pc_src   = 2'b01;
            end
            state_d = S_IF;
          end
          OP_J, OP_JAL: begin
            pc_write = 1'b1;
            pc_src   = 2'b10;
            state_d  = is_jal ? S_WB : S_IF;
          end
          OP_LW: state_d = S_LD;
          OP_SW: state_d = S_ST;
          OP_ADDIU, OP_SLTI, OP_ANDI, OP_ORI, OP_XORI: state_d = S_WB;
          default: state_d = S_IF;
        endcase
      end
      S_LD: begin
        alu_code           = dec_alu_code;
        additional_control = dec_addl;
        data_req           = 1'b1;
        if (data_ready) state_d = S_WB;
      end
      S_ST: begin
        alu_code           = dec_alu_code;
        additional_control = dec_addl;
        data_req           = 1'b1;
        mem_write          = 1'b1;
        if (data_ready) state_d = S_IF;
      end
      S_WB: begin
        reg_write = 1'b1;
        if (is_jal)        reg_dst = 2'b10;
        else if (is_rtype) reg_dst = 2'b01;
        if (opcode == OP_LW)        wb_src = 2'b01;
        else if (is_jal || is_jalr) wb_src = 2'b10;
        state_d = S_IF;
      end
      default: state_d = S_IF;
    endcase

    if (rst) begin
      state_d            = S_IF;
      inst_req           = 1'b0;
      data_req           = 1'b0;
      mem_write          = 1'b0;
      ir_write           = 1'b0;
      pc_write           = 1'b0;
      pc_src             = 2'b00;
      reg_write          = 1'b0;
      wb_src             = 2'b00;
      reg_dst            = 2'b00;
      alu_code           = 2'b00;
      additional_control = 3'b000;
    end
  end

  // Count an instruction as retired whenever control returns to IF.
  always_comb begin
    retire_d = retire_q;
    if ((state_q != S_IF) && (state_d == S_IF)) retire_d = retire_q + 32'd1;
  end

  // State and retire counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IF;
      retire_q <= 32'd0;
    end else begin
      state_q  <= state_d;
      retire_q <= retire_d;
    end
  end

  assign state      = state_q;
  assign retire_cnt = retire_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed bench for mips_multicycle_ctrl. Inputs change 1 time unit after the
// rising edge; outputs are checked 1 unit later, well before the next edge.
module tb_mips_multicycle_ctrl;

  logic        clk, rst;
  logic [5:0]  opcode, funct;
  logic        alu_zero, inst_ready, data_ready;
  logic        inst_req, data_req, mem_write, ir_write, pc_write, reg_write;
  logic [1:0]  pc_src, wb_src, reg_dst, alu_code;
  logic [2:0]  additional_control, state;
  logic [31:0] retire_cnt;

  int n_assert = 0;
  int n_fail   = 0;

  mips_multicycle_ctrl dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .alu_zero(alu_zero),
    .inst_ready(inst_ready), .data_ready(data_ready), .inst_req(inst_req),
    .data_req(data_req), .mem_write(mem_write), .ir_write(ir_write),
    .pc_write(pc_write), .pc_src(pc_src), .reg_write(reg_write),
    .wb_src(wb_src), .reg_dst(reg_dst), .alu_code(alu_code),
    .additional_control(additional_control), .state(state),
    .retire_cnt(retire_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; opcode = 6'd0; funct = 6'd0; alu_zero = 1'b0;
    inst_ready = 1'b0; data_ready = 1'b0;
    cyc(); cyc();
    #1;
    chk("rst_state", {29'd0, state}, 32'd0);
    chk("rst_inst_req", {31'd0, inst_req}, 32'd0);
    chk("rst_retire", retire_cnt, 32'd0);

    // addu, zero-wait: 0,1,2,5,0
    rst = 1'b0; opcode = 6'b000000; funct = 6'b100001; inst_ready = 1'b1;
    #1;
    chk("addu_if_state", {29'd0, state}, 32'd0);
    chk("addu_if_inst_req", {31'd0, inst_req}, 32'd1);
    chk("addu_if_strobes", {29'd0, ir_write, pc_write, reg_write}, 32'b110);
    chk("addu_if_pc_src", {30'd0, pc_src}, 32'd0);
    cyc(); #1;
    chk("addu_id_state", {29'd0, state}, 32'd1);
    chk("addu_id_pc_write", {31'd0, pc_write}, 32'd0);
    cyc(); #1;
    chk("addu_ex_state", {29'd0, state}, 32'd2);
    chk("addu_ex_alu_code", {30'd0, alu_code}, 32'd2);
    chk("addu_ex_pc_write", {31'd0, pc_write}, 32'd0);
    cyc(); #1;
    chk("addu_wb_state", {29'd0, state}, 32'd5);
    chk("addu_wb_reg_write", {31'd0, reg_write}, 32'd1);
    chk("addu_wb_reg_dst", {30'd0, reg_dst}, 32'd1);
    chk("addu_wb_wb_src", {30'd0, wb_src}, 32'd0);
    chk("addu_wb_alu_code", {30'd0, alu_code}, 32'd0);
    cyc(); #1;
    chk("addu_done_state", {29'd0, state}, 32'd0);
    chk("addu_retire", retire_cnt, 32'd1);

    // lw with data_ready low for three LD cycles: 8 cycles total
    opcode = 6'b100011; funct = 6'd0;
    cyc(); cyc(); #1;
    chk("lw_ex_state", {29'd0, state}, 32'd2);
    chk("lw_ex_alu", {27'd0, alu_code, additional_control}, 32'd0);
    cyc();
    for (int i = 0; i < 4; i++) begin
      data_ready = (i == 3);
      #1;
      chk("lw_ld_state", {29'd0, state}, 32'd3);
      chk("lw_ld_req", {29'd0, data_req, mem_write, reg_write}, 32'b100);
      cyc();
    end
    data_ready = 1'b0;
    #1;
    chk("lw_wb_state", {29'd0, state}, 32'd5);
    chk("lw_wb_reg_write", {31'd0, reg_write}, 32'd1);
    chk("lw_wb_wb_src", {30'd0, wb_src}, 32'd1);
    chk("lw_wb_reg_dst", {30'd0, reg_dst}, 32'd0);
    chk("lw_wb_data_req", {31'd0, data_req}, 32'd0);
    cyc(); #1;
    chk("lw_retire", retire_cnt, 32'd2);

    // beq taken
    opcode = 6'b000100; alu_zero = 1'b1;
    cyc(); cyc(); #1;
    chk("beq_t_ex_state", {29'd0, state}, 32'd2);
    chk("beq_t_pc", {29'd0, pc_write, pc_src}, 32'b101);
    chk("beq_t_alu_code", {30'd0, alu_code}, 32'd1);
    cyc(); #1;
    chk("beq_t_done", {29'd0, state}, 32'd0);

    // beq not taken
    alu_zero = 1'b0;
    cyc(); cyc(); #1;
    chk("beq_n_ex_state", {29'd0, state}, 32'd2);
    chk("beq_n_pc_write", {31'd0, pc_write}, 32'd0);
    cyc(); #1;
    chk("beq_n_done", {29'd0, state}, 32'd0);
    chk("beq_retire", retire_cnt, 32'd4);

    // bne taken on non-zero
    opcode = 6'b000101; alu_zero = 1'b0;
    cyc(); cyc(); #1;
    chk("bne_pc", {29'd0, pc_write, pc_src}, 32'b101);
    alu_zero = 1'b1;
    #1;
    chk("bne_zero_pc_write", {31'd0, pc_write}, 32'd0);
    cyc(); #1;
    chk("bne_retire", retire_cnt, 32'd5);

    // jal with one cycle of inst_ready low
    opcode = 6'b000011; alu_zero = 1'b0; inst_ready = 1'b0;
    #1;
    chk("jal_wait_req", {29'd0, inst_req, ir_write, pc_write}, 32'b100);
    cyc();
    inst_ready = 1'b1;
    #1;
    chk("jal_if_state", {29'd0, state}, 32'd0);
    chk("jal_if_ir_write", {31'd0, ir_write}, 32'd1);
    cyc(); cyc(); #1;
    chk("jal_ex_pc", {29'd0, pc_write, pc_src}, 32'b110);
    cyc(); #1;
    chk("jal_wb_state", {29'd0, state}, 32'd5);
    chk("jal_wb_sel", {27'd0, reg_write, reg_dst, wb_src}, 32'b11010);
    cyc(); #1;
    chk("jal_retire", retire_cnt, 32'd6);

    // ori
    opcode = 6'b001101;
    cyc(); cyc(); #1;
    chk("ori_ex_alu", {27'd0, alu_code, additional_control}, 32'b00011);
    chk("ori_ex_pc_write", {31'd0, pc_write}, 32'd0);
    cyc(); #1;
    chk("ori_wb_sel", {27'd0, reg_write, reg_dst, wb_src}, 32'b10000);
    cyc(); #1;
    chk("ori_retire", retire_cnt, 32'd7);

    // jr: register target, no writeback
    opcode = 6'b000000; funct = 6'b001000;
    cyc(); cyc(); #1;
    chk("jr_ex_pc", {29'd0, pc_write, pc_src}, 32'b111);
    cyc(); #1;
    chk("jr_done_state", {29'd0, state}, 32'd0);
    chk("jr_retire", retire_cnt, 32'd8);

    // sw aborted by reset while waiting for data_ready
    opcode = 6'b101011; funct = 6'd0; data_ready = 1'b0;
    cyc(); cyc(); cyc(); cyc(); #1;
    chk("sw_st_state", {29'd0, state}, 32'd4);
    chk("sw_st_req", {30'd0, data_req, mem_write}, 32'b11);
    rst = 1'b1;
    #1;
    chk("sw_rst_state", {29'd0, state}, 32'd0);
    chk("sw_rst_strobes", {26'd0, inst_req, data_req, mem_write, ir_write, pc_write, reg_write}, 32'd0);
    chk("sw_rst_alu", {27'd0, alu_code, additional_control}, 32'd0);
    chk("sw_rst_retire", retire_cnt, 32'd0);
    cyc();
    rst = 1'b0;
    #1;
    chk("post_rst_inst_req", {31'd0, inst_req}, 32'd1);

    // counter wrap on an unknown opcode treated as nop
    opcode = 6'b111111;
    cyc(); #1;
    chk("nop_id_state", {29'd0, state}, 32'd1);
    force dut.retire_q = 32'hFFFF_FFFF;
    #1;
    release dut.retire_q;
    #1;
    chk("wrap_preload", retire_cnt, 32'hFFFF_FFFF);
    cyc(); #1;
    chk("nop_ex_strobes", {29'd0, pc_write, reg_write, data_req}, 32'd0);
    cyc(); #1;
    chk("nop_done_state", {29'd0, state}, 32'd0);
    chk("wrap_retire", retire_cnt, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
